// File: rtl/rd53_to_hit_digitizer.sv
// rd53_to_hit_digitizer
// Drives the RD53 "TO" discriminator latch (STROBE_TO, PHI_AZ_TO), samples the
// active-low differential latch output once per strobe and turns each hit into
// a {timestamp, ToT} record, buffered in a small valid/ready FIFO.
// Optional feature macro: RD53_TO_AUTOZERO_EN
//   defined   : periodic auto-zero phase (AZ state, PHI_AZ_TO pulses)
//   undefined : no auto-zero, PHI_AZ_TO tied low, continuous strobing
module rd53_to_hit_digitizer #(
  parameter int TOT_W      = 4,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AZ_PERIOD  = 64,
  parameter int AZ_LEN     = 4
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             ENABLE,
  input  logic [TS_W-1:0]  TS_IN,
  input  logic             VOUTP_TO,
  input  logic             VOUTN_TO,
  output logic             STROBE_TO,
  output logic             PHI_AZ_TO,
  output logic             HIT_VALID,
  input  logic             HIT_READY,
  output logic [TS_W-1:0]  HIT_TS,
  output logic [TOT_W-1:0] HIT_TOT,
  output logic [7:0]       DROP_CNT,
  output logic [7:0]       ERR_CNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = TS_W + TOT_W;
  localparam logic [TOT_W-1:0] TOT_MAX   = '1;
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  function automatic logic [TOT_W-1:0] tot_sat_inc(input logic [TOT_W-1:0] v);
    return (v == TOT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] cnt_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef RD53_TO_AUTOZERO_EN
  typedef enum logic [1:0] {S_IDLE, S_TOT, S_AZ} state_t;
`else
  typedef enum logic {S_IDLE, S_TOT} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             phase;
  logic             strobe_run;
  logic             sample;
  logic             code_hit;
  logic             code_err;
  logic             ts_load;
  logic             tot_inc;
  logic             rec_push;

  logic [TS_W-1:0]  ts_q;
  logic [TOT_W-1:0] tot_q;

  logic             vld_p0;
  logic [TS_W-1:0]  ts_p0;
  logic [TOT_W-1:0] tot_p0;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [REC_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;
  logic             do_drop;

  logic [7:0]       drop_q;
  logic [7:0]       err_q;

  // A sample edge is one where the strobe is currently high; the latch has
  // settled well before the next CLK edge.
  assign sample   = phase & ENABLE;
  assign code_hit = ~VOUTP_TO &  VOUTN_TO;
  assign code_err = ~VOUTP_TO & ~VOUTN_TO;

`ifdef RD53_TO_AUTOZERO_EN
  localparam int AZC_W = $clog2(2 * AZ_LEN);
  localparam int SMP_W = $clog2(AZ_PERIOD + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(AZ_PERIOD);
  localparam logic [AZC_W-1:0] AZC_LAST = AZC_W'(2 * AZ_LEN - 1);

  logic [SMP_W-1:0] smp_cnt;
  logic [AZC_W-1:0] az_cnt;
  logic             az_req;
  logic             az_done;

  assign az_req  = (smp_cnt == SMP_LAST);
  assign az_done = (az_cnt == AZC_LAST);

  // Count samples toward the next auto-zero; holds at the request value while deferred.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)                        smp_cnt <= '0;
    else if (state == S_AZ && az_done) smp_cnt <= '0;
    else if (sample && !az_req)        smp_cnt <= smp_cnt + 1'b1;
  end

  // Time the auto-zero window in CLK cycles (AZ_LEN strobe periods).
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)                         az_cnt <= '0;
    else if (state == S_AZ && !az_done) az_cnt <= az_cnt + 1'b1;
    else                                az_cnt <= '0;
  end

  // PHI_AZ_TO is registered from the state being entered so it aligns with AZ.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) PHI_AZ_TO <= 1'b0;
    else        PHI_AZ_TO <= (state_nxt == S_AZ);
  end

  // Strobe is parked low for the whole auto-zero window, including its first cycle.
  assign strobe_run = ENABLE && (state_nxt != S_AZ);
`else
  assign PHI_AZ_TO  = 1'b0;
  assign strobe_run = ENABLE;
`endif

  // Next-state decode: hit start, ToT accumulation, record push, auto-zero scheduling.
  always_comb begin
    state_nxt = state;
    ts_load   = 1'b0;
    tot_inc   = 1'b0;
    rec_push  = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef RD53_TO_AUTOZERO_EN
        if (az_req) begin
          state_nxt = S_AZ;
        end else
`endif
        if (sample && code_hit) begin
          state_nxt = S_TOT;
          ts_load   = 1'b1;
        end
      end
      S_TOT: begin
        if (!ENABLE) begin
          rec_push  = 1'b1;
          state_nxt = S_IDLE;
        end else if (sample) begin
          if (code_hit) begin
            tot_inc = 1'b1;
          end else begin
            rec_push  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
`ifdef RD53_TO_AUTOZERO_EN
      S_AZ: begin
        if (az_done) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Strobe phase: toggles every CLK while running, parked low otherwise.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) phase <= 1'b0;
    else        phase <= strobe_run ? ~phase : 1'b0;
  end

  assign STROBE_TO = phase;

  // Hit accumulator: timestamp at the leading sample, saturating ToT.
  always_ff @(posedge CLK) begin
    if (ts_load) begin
      ts_q  <= TS_IN;
      tot_q <= TOT_W'(1);
    end else if (tot_inc) begin
      tot_q <= tot_sat_inc(tot_q);
    end
  end

  // Illegal 00 latch codes, counted on sample edges only.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)                    err_q <= '0;
    else if (sample && code_err)   err_q <= cnt_sat_inc(err_q);
  end

  // ---- p0: completed record staged one cycle before the FIFO write ----
  // Push-valid (control) for the staged record.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) vld_p0 <= 1'b0;
    else        vld_p0 <= rec_push;
  end

  // Staged record payload.
  always_ff @(posedge CLK) begin
    if (rec_push) begin
      ts_p0  <= ts_q;
      tot_p0 <= tot_q;
    end
  end

  // ---- FIFO: write of p0 record, head pop toward readout ----
  assign fifo_full = (count == FIFO_FULL);
  assign HIT_VALID = (count != '0);
  assign do_pop    = HIT_VALID & HIT_READY;
  assign do_push   = vld_p0 & (~fifo_full | do_pop);
  assign do_drop   = vld_p0 & fifo_full & ~do_pop;

  // Record storage.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= {ts_p0, tot_p0};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Records lost because the FIFO was full with no pop in the same cycle.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)       drop_q <= '0;
    else if (do_drop) drop_q <= cnt_sat_inc(drop_q);
  end

  // Head is forced to zero when empty so outputs read 0 out of reset.
  assign head     = mem[rd_ptr];
  assign HIT_TS   = HIT_VALID ? head[REC_W-1:TOT_W] : '0;
  assign HIT_TOT  = HIT_VALID ? head[TOT_W-1:0]     : '0;
  assign DROP_CNT = drop_q;
  assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_rd53_to_hit_digitizer.sv
// Testbench for rd53_to_hit_digitizer: directed scenarios plus randomized
// latch/readout traffic against a record-level reference model.
// Build with RD53_TO_AUTOZERO_EN defined to exercise the auto-zero scenarios.
`timescale 1ns/100ps
module tb_rd53_to_hit_digitizer;

  localparam int TOT_W     = 4;
  localparam int TS_W      = 8;
  localparam int DEPTH     = 4;
  localparam int AZ_PERIOD = 8;
  localparam int AZ_LEN    = 2;

  logic             clk;
  logic             rst_b;
  logic             enable;
  logic [TS_W-1:0]  ts_in;
  logic             voutp;
  logic             voutn;
  logic             strobe_to;
  logic             phi_az_to;
  logic             hit_valid;
  logic             hit_ready;
  logic [TS_W-1:0]  hit_ts;
  logic [TOT_W-1:0] hit_tot;
  logic [7:0]       drop_cnt;
  logic [7:0]       err_cnt;

  rd53_to_hit_digitizer #(
    .TOT_W(TOT_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH),
    .AZ_PERIOD(AZ_PERIOD), .AZ_LEN(AZ_LEN)
  ) dut (
    .CLK(clk), .RST_B(rst_b), .ENABLE(enable), .TS_IN(ts_in),
    .VOUTP_TO(voutp), .VOUTN_TO(voutn), .STROBE_TO(strobe_to),
    .PHI_AZ_TO(phi_az_to), .HIT_VALID(hit_valid), .HIT_READY(hit_ready),
    .HIT_TS(hit_ts), .HIT_TOT(hit_tot), .DROP_CNT(drop_cnt), .ERR_CNT(err_cnt)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [TOT_W-1:0] tot;
  } rec_t;

  // Reference model: records derived from the sequence of sampled latch codes.
  rec_t            q[$];
  rec_t            pend;
  bit              pend_v;
  bit              in_hit;
  int              run;
  logic [TS_W-1:0] hit_start_ts;
  int              m_drop;
  int              m_err;

  int              checks;
  int              failures;
  logic [TS_W-1:0] last_ts;
  logic [TS_W-1:0] exp_ts [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend_v = 0;
    in_hit = 0;
    run    = 0;
    m_drop = 0;
    m_err  = 0;
  endtask

  task automatic check_outputs();
    chk("hit_valid", hit_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("hit_ts", hit_ts, q[0].ts);
      chk("hit_tot", hit_tot, q[0].tot);
    end else begin
      chk("hit_ts_empty", hit_ts, 0);
      chk("hit_tot_empty", hit_tot, 0);
    end
    chk("drop_cnt", drop_cnt, m_drop);
    chk("err_cnt", err_cnt, m_err);
`ifndef RD53_TO_AUTOZERO_EN
    chk("phi_az_tied", phi_az_to, 0);
`endif
  endtask

  // One CLK cycle: capture pre-edge inputs, advance the model, check after the edge.
  task automatic tick();
    logic            strb;
    logic            en;
    logic            rdy;
    logic [1:0]      code;
    logic [TS_W-1:0] ts_now;
    strb   = strobe_to;
    en     = enable;
    rdy    = hit_ready;
    code   = {voutp, voutn};
    ts_now = ts_in;
    @(posedge clk);
    if ((q.size() > 0) && rdy) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() >= DEPTH) begin
        if (m_drop < 255) m_drop++;
      end else begin
        q.push_back(pend);
      end
      pend_v = 0;
    end
    if (in_hit && !en) begin
      pend.ts  = hit_start_ts;
      pend.tot = TOT_W'((run > 15) ? 15 : run);
      pend_v   = 1;
      in_hit   = 0;
    end else if (strb && en) begin
      if (code == 2'b01) begin
        if (in_hit) begin
          run++;
        end else begin
          in_hit       = 1;
          run          = 1;
          hit_start_ts = ts_now;
        end
      end else begin
        if (in_hit) begin
          pend.ts  = hit_start_ts;
          pend.tot = TOT_W'((run > 15) ? 15 : run);
          pend_v   = 1;
          in_hit   = 0;
        end
        if (code == 2'b00 && m_err < 255) m_err++;
      end
    end
    #1;
    ts_in = ts_in + 1'b1;
    check_outputs();
  endtask

  task automatic wait_strobe();
    int guard;
    guard = 0;
    while (!(strobe_to === 1'b1 && enable === 1'b1) && guard < 40) begin
      tick();
      guard++;
    end
    chk("strobe_wait", guard < 40, 1);
  endtask

  task automatic do_sample(input logic [1:0] code);
    voutp = code[1];
    voutn = code[0];
    wait_strobe();
    last_ts = ts_in;
    tick();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    model_clear();
    #1;
    chk("rst_strobe", strobe_to, 0);
    chk("rst_phi", phi_az_to, 0);
    chk("rst_valid", hit_valid, 0);
    chk("rst_ts", hit_ts, 0);
    chk("rst_tot", hit_tot, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err_cnt, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [1:0] rcode;
    int         r;
    int         len;
    checks    = 0;
    failures  = 0;
    rst_b     = 1'b0;
    enable    = 1'b1;
    ts_in     = '0;
    voutp     = 1'b1;
    voutn     = 1'b0;
    hit_ready = 1'b1;
    model_clear();

    // Reset values, then first strobe one CLK after release.
    do_reset();
    tick();
    chk("first_strobe", strobe_to, 1);

`ifdef RD53_TO_AUTOZERO_EN
    // Idle auto-zero after 8 samples: PHI high 4 CLK with strobe low.
    repeat (8) do_sample(2'b10);
    chk("az_not_yet", phi_az_to, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("az_phi", phi_az_to, 1);
      chk("az_strobe_low", strobe_to, 0);
    end
    tick();
    chk("az_end_phi", phi_az_to, 0);
    chk("az_end_strobe", strobe_to, 1);

    // Hit in progress at the 8th sample defers auto-zero until after its push.
    repeat (7) do_sample(2'b10);
    repeat (3) do_sample(2'b01);
    chk("az_defer", phi_az_to, 0);
    do_sample(2'b10);
    chk("az_defer_push", phi_az_to, 0);
    tick();
    chk("az_after_push", phi_az_to, 1);
    chk("az_rec_valid", hit_valid, 1);
    repeat (5) tick();
`endif

    // 3-sample hit at TS 0x2A, latency of HIT_VALID.
    hit_ready = 1'b1;
    repeat (4) tick();
    hit_ready = 1'b0;
    voutp = 1'b1;
    voutn = 1'b0;
    wait_strobe();
    ts_in = 8'h2A;
    repeat (3) do_sample(2'b01);
    do_sample(2'b10);
    chk("lat_early", hit_valid, 0);
    tick();
    chk("lat_valid", hit_valid, 1);
    chk("t1_ts", hit_ts, 8'h2A);
    chk("t1_tot", hit_tot, 3);
    hit_ready = 1'b1;
    tick();

    // 20-sample hit saturates ToT at 15, single record.
    repeat (20) do_sample(2'b01);
    do_sample(2'b10);
    tick();
    chk("sat_valid", hit_valid, 1);
    chk("sat_tot", hit_tot, 15);
    tick();
    chk("sat_single", hit_valid, 0);

    // ENABLE falls during a hit: record pushed with current ToT.
    repeat (2) do_sample(2'b01);
    enable = 1'b0;
    tick();
    chk("en_drop_pending", hit_valid, 0);
    tick();
    chk("en_drop_valid", hit_valid, 1);
    chk("en_drop_tot", hit_tot, 2);
    enable = 1'b1;
    repeat (2) tick();

    // Illegal codes counted, unresolved codes not, no records.
    do_reset();
    repeat (3) do_sample(2'b00);
    repeat (2) do_sample(2'b11);
    do_sample(2'b10);
    tick();
    chk("err_count", err_cnt, 3);
    chk("err_no_rec", hit_valid, 0);

    // Six 1-sample hits with readout stalled: four kept in order, two dropped.
    do_reset();
    hit_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_sample(2'b01);
      exp_ts[k] = last_ts;
      do_sample(2'b10);
    end
    tick();
    chk("drop_count", drop_cnt, 2);
    chk("drop_full_valid", hit_valid, 1);
    hit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drop_order_ts", hit_ts, exp_ts[k]);
      chk("drop_order_tot", hit_tot, 1);
      tick();
    end
    chk("drop_drained", hit_valid, 0);

    // Reset pulsed in the middle of a 5-sample hit with a record queued.
    hit_ready = 1'b0;
    do_sample(2'b01);
    do_sample(2'b10);
    tick();
    chk("pre_rst_valid", hit_valid, 1);
    repeat (2) do_sample(2'b01);
    do_reset();
    voutp = 1'b1;
    voutn = 1'b0;
    repeat (12) tick();
    chk("rst_no_record", hit_valid, 0);
    hit_ready = 1'b1;

    // Randomized latch codes, readout back-pressure and ENABLE gaps.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      rcode = 2'b01;
      else if (r < 85) rcode = 2'b10;
      else if (r < 95) rcode = 2'b11;
      else             rcode = 2'b00;
      voutp = rcode[1];
      voutn = rcode[0];
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        hit_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 29) != 0);
        tick();
      end
    end
    enable    = 1'b1;
    hit_ready = 1'b1;
    voutp     = 1'b1;
    voutn     = 1'b0;
    repeat (20) tick();
    chk("rand_drained", hit_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd53_to_hit_digitizer.md
# rd53_to_hit_digitizer

Per-pixel digital stage directly downstream of the RD53 "TO" analog front-end. It drives the discriminator latch control lines, STROBE_TO and PHI_AZ_TO. It samples the differential active-low latch outputs VOUTP_TO/VOUTN_TO once per strobe and converts each hit into a {timestamp, ToT} record. Records are buffered in a small FIFO with a valid/ready handshake toward the pixel-region readout.

## Interface
- TOT_W, 4, ToT field width; counts strobe samples and saturates at 2^TOT_W-1.
- TS_W, 8, timestamp width.
- FIFO_DEPTH, 4, record buffer depth; power of two, ≥2.
- AZ_PERIOD, 64, samples between auto-zero phases (≥4).
- AZ_LEN, 4, samples PHI_AZ_TO is held high (≥1).

Ports:
- CLK  in  1  fast clock (5 ns nominal); all logic on its rising edge.
- RST_B  in  1  asynchronous, active-low reset.
- ENABLE  in  1  0 = strobe generation stopped, no new hits; FIFO still drains.
- TS_IN  in  TS_W  free-running timestamp; captured at the hit leading-edge sample.
- VOUTP_TO  in  1  latch output, active-low hit.
- VOUTN_TO  in  1  latch complement.
- STROBE_TO  out  1  latch strobe, registered.
- PHI_AZ_TO  out  1  auto-zero phase, registered.
- HIT_VALID  out  1  FIFO head valid.
- HIT_READY  in  1  consumer accepts head.
- HIT_TS  out  TS_W  head timestamp.
- HIT_TOT  out  TOT_W  head ToT.
- DROP_CNT  out  8  records lost to FIFO full; saturating.
- ERR_CNT  out  8  illegal latch codes (00); saturating.

## Operation
- Strobe: phase bit toggles every CLK while ENABLE=1 and state≠AZ. STROBE_TO = phase. This gives a 50% duty cycle and one sample per 2 CLK.
- Sample edge: the rising edge at which STROBE_TO=1. The latch settles 500 ps after the strobe rises, so the decision is valid.
- Decode {VOUTP,VOUTN}:
  - 01 → hit.
  - 10 → no hit.
  - 11 → no hit; unresolved, not counted as an error.
  - 00 → no hit; ERR_CNT+1.
- FSM states: IDLE, TOT, AZ.
  - IDLE, hit sample: capture TS_IN, set tot=1, go to TOT.
  - TOT, hit sample: tot+1, saturating at 2^TOT_W-1.
  - TOT, no-hit sample: push {ts, tot} and go to IDLE. If the FIFO is full and there is no pop in the same cycle, drop the record and add 1 to DROP_CNT.
  - IDLE: when the sample counter reaches AZ_PERIOD, go to AZ.
    - In AZ: STROBE_TO=0, PHI_AZ_TO=1 for AZ_LEN×2 CLK, then return to IDLE and clear the counter.
  - TOT: an AZ request is deferred until the return to IDLE.
- ENABLE falling while in TOT: the next edge pushes the record with its current tot, then goes to IDLE.
- FIFO: pop when HIT_VALID&&HIT_READY. When full, a simultaneous push and pop both succeed.
- HIT_TS/HIT_TOT hold stable while HIT_VALID=1 and HIT_READY=0.

## Timing
- Reset values:
  - STROBE_TO=0, PHI_AZ_TO=0, HIT_VALID=0.
  - HIT_TS=0, HIT_TOT=0, DROP_CNT=0, ERR_CNT=0.
  - State IDLE, phase 0, FIFO empty.
- First STROBE_TO=1 occurs 1 CLK after RST_B deasserts with ENABLE=1.
- Latency: HIT_VALID rises 1 CLK after the trailing no-hit sample edge when the FIFO was empty.
- Reset asserted mid-hit or mid-AZ: all outputs return to reset values immediately; the partial record is discarded.

## Configuration
- RD53_TO_AUTOZERO_EN:
  - Defined: AZ state, AZ_PERIOD/AZ_LEN counters and PHI_AZ_TO behave as specified above.
  - Undefined: no AZ state, PHI_AZ_TO tied to 0, and strobing is continuous whenever ENABLE=1.

## Test plan
- Latch model returns 01 for exactly 3 consecutive samples, TS_IN=0x2A at the first → one record {0x2A, 3}; HIT_VALID 1 CLK after the trailing sample.
- Hit held for 20 samples, TOT_W=4 → HIT_TOT=15 (saturated), single record.
- HIT_READY=0, 6 separate 1-sample hits, FIFO_DEPTH=4 → 4 records retained in order, DROP_CNT=2.
- Latch forced to 00 for 3 samples, then 11 for 2 samples → ERR_CNT=3, no records.
- RD53_TO_AUTOZERO_EN defined, AZ_PERIOD=8, AZ_LEN=2:
  - Idle → PHI_AZ_TO high 4 CLK after 8 samples, STROBE_TO low throughout.
  - Hit in progress at the 8th sample → AZ starts only after its record is pushed.
- RST_B pulsed low during a 5-sample hit → outputs at reset values, FIFO empty, no record emitted.
